// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
// The master side is the word source; the slave side is the transmitter.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             valid;
    logic             ready;
    logic             x;
    logic             busy;
    logic             frame_done;

    modport master (output din, valid, input ready, x, busy, frame_done);
    modport slave  (input din, valid, output ready, x, busy, frame_done);
endinterface

// File: rtl/serial_frame_tx.sv
// Bit-serial frame transmitter: 3-bit sync, WIDTH data bits MSB first, then
// GAP_BITS idle bit times. Every bit is held for BIT_CYCLES clocks and x is
// registered, so the first sync bit appears on the accept edge itself.
module serial_frame_tx #(
    parameter int         WIDTH      = 8,
    parameter logic [2:0] SYNC       = 3'b011,
    parameter int         BIT_CYCLES = 1,
    parameter int         GAP_BITS   = 1,
    parameter logic       IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    serial_frame_tx_if.slave bus
);
    // Bit index must reach the longest phase: 3 sync bits, WIDTH data bits or GAP_BITS.
    localparam int MAX_SW = (WIDTH > 3) ? WIDTH : 3;
    localparam int MAX_B  = (GAP_BITS > MAX_SW) ? GAP_BITS : MAX_SW;
    localparam int IDX_W  = $clog2(MAX_B);
    localparam int CYC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_x, w_x_nxt;
    logic             r_done, w_done_nxt;
    logic             w_accept;
    logic             w_adv;

    assign w_accept = bus.valid && (r_state == S_IDLE);
    // A bit time ends when the per-bit clock counter wraps.
    assign w_adv    = (r_cyc == CYC_W'(BIT_CYCLES - 1));

    // Next-state, counters and the line level that the next state will drive.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_x_nxt     = IDLE_LEVEL;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SYNC;
                    w_cyc_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_data_nxt  = bus.din;
                end
            end
            S_SYNC: begin
                if (w_adv) begin
                    w_cyc_nxt = '0;
                    if (r_idx == IDX_W'(2)) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            S_DATA: begin
                if (w_adv) begin
                    w_cyc_nxt  = '0;
                    // Data leaves from the MSB, so shift the next bit into place.
                    w_data_nxt = r_data << 1;
                    if (r_idx == IDX_W'(WIDTH - 1)) begin
                        w_state_nxt = S_GAP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            S_GAP: begin
                if (w_adv) begin
                    w_cyc_nxt = '0;
                    if (r_idx == IDX_W'(GAP_BITS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_SYNC: begin
                case (w_idx_nxt)
                    IDX_W'(0): w_x_nxt = SYNC[2];
                    IDX_W'(1): w_x_nxt = SYNC[1];
                    default:   w_x_nxt = SYNC[0];
                endcase
            end
            S_DATA:  w_x_nxt = w_data_nxt[WIDTH-1];
            default: w_x_nxt = IDLE_LEVEL;
        endcase
    end

    // State, counters, data and registered line/done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_x     <= IDLE_LEVEL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_x     <= w_x_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.x          = r_x;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a BIT_CYCLES=1 instance and a BIT_CYCLES=4
// instance share clock and reset. Expected line values come from the frame
// picture {sync, word, gap} stretched by the bit time.
module tb_serial_frame_tx;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx_if #(.WIDTH(8)) if1 ();
    serial_frame_tx_if #(.WIDTH(8)) if4 ();

    serial_frame_tx #(.WIDTH(8), .SYNC(3'b011), .BIT_CYCLES(1), .GAP_BITS(1), .IDLE_LEVEL(1'b0))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    serial_frame_tx #(.WIDTH(8), .SYNC(3'b011), .BIT_CYCLES(4), .GAP_BITS(1), .IDLE_LEVEL(1'b0))
        dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

    int total = 0;
    int bad   = 0;
    logic [2:0] sync_v = 3'b011;

    // Whole frame as transmitted, bit 11 first: sync, word MSB first, one gap bit.
    function automatic logic [11:0] frame_of(input logic [7:0] d);
        return {sync_v, d, 1'b0};
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 4) begin if4.valid = v; if4.din = d; end
        else          begin if1.valid = v; if1.din = d; end
    endtask

    // {x, frame_done, ready, busy}
    function automatic logic [3:0] obs(input int sel);
        return (sel == 4) ? {if4.x, if4.frame_done, if4.ready, if4.busy}
                          : {if1.x, if1.frame_done, if1.ready, if1.busy};
    endfunction

    // Accept one word and check every cycle of the frame through the done cycle.
    task automatic send_and_check(input int sel, input logic [7:0] d, input bit now, input string tag);
        int bc = (sel == 4) ? 4 : 1;
        int len = 12 * bc;
        logic [11:0] fr = frame_of(d);
        logic [3:0] o;
        logic ex;
        if (!now) @(negedge clk);
        drive(sel, 1'b1, d);
        @(posedge clk);
        #1 drive(sel, 1'b0, 8'($urandom));
        for (int n = 0; n <= len; n++) begin
            @(negedge clk);
            o  = obs(sel);
            ex = (n < len) ? fr[11 - n / bc] : 1'b0;
            total++; if (o[3] !== ex) begin bad++; $display("FAIL %s x n=%0d got=%b exp=%b", tag, n, o[3], ex); end
            total++; if (o[2] !== (n == len)) begin bad++; $display("FAIL %s frame_done n=%0d got=%b exp=%b", tag, n, o[2], (n == len)); end
            total++; if (o[1] !== (n == len)) begin bad++; $display("FAIL %s ready n=%0d got=%b exp=%b", tag, n, o[1], (n == len)); end
            total++; if (o[0] !== (n < len)) begin bad++; $display("FAIL %s busy n=%0d got=%b exp=%b", tag, n, o[0], (n < len)); end
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        logic [3:0] o = obs(sel);
        total++; if (o !== 4'b0010) begin bad++; $display("FAIL %s idle sel=%0d {x,done,ready,busy} got=%b exp=0010", tag, sel, o); end
    endtask

    task automatic test_reset;
        drive(1, 1'b0, 8'h00);
        drive(4, 1'b0, 8'h00);
        #1;
        check_idle(1, "reset");
        check_idle(4, "reset");
        // valid during reset must not start anything
        drive(1, 1'b1, 8'hFF);
        drive(4, 1'b1, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        check_idle(1, "reset_valid");
        check_idle(4, "reset_valid");
        drive(1, 1'b0, 8'h00);
        drive(4, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single;
        send_and_check(1, 8'hA5, 0, "single_A5");
    endtask

    task automatic test_stretch;
        send_and_check(4, 8'h80, 0, "stretch_80");
        send_and_check(4, 8'($urandom), 0, "stretch_rand");
    endtask

    // valid held across two words; ready is high in the frame_done cycle, so
    // the held valid is taken on the edge that closes that cycle.
    task automatic test_back_to_back;
        int len = 12;
        int pulses = 0;
        logic [11:0] fa = frame_of(8'hFF);
        logic [11:0] fb = frame_of(8'h00);
        logic [3:0] o;
        logic ex;
        @(negedge clk);
        drive(1, 1'b1, 8'hFF);
        @(posedge clk);
        #1 if1.din = 8'h00;
        for (int n = 0; n <= 2 * len + 5; n++) begin
            @(negedge clk);
            o = obs(1);
            if (n < len)                ex = fa[11 - n];
            else if (n == len)          ex = 1'b0;
            else if (n < 2 * len + 1)   ex = fb[11 - (n - len - 1)];
            else                        ex = 1'b0;
            if (o[2] === 1'b1) pulses++;
            total++; if (o[3] !== ex) begin bad++; $display("FAIL b2b x n=%0d got=%b exp=%b", n, o[3], ex); end
            total++; if (o[2] !== (n == len || n == 2 * len + 1)) begin bad++; $display("FAIL b2b frame_done n=%0d got=%b", n, o[2]); end
            if (n == len) begin
                @(posedge clk);
                #1 if1.valid = 1'b0;
            end
        end
        total++; if (pulses !== 2) begin bad++; $display("FAIL b2b pulses got=%0d exp=2", pulses); end
    endtask

    // A one-cycle valid while busy must be dropped, not queued.
    task automatic test_busy_valid;
        int len = 12;
        logic [11:0] fr = frame_of(8'hA5);
        logic [3:0] o;
        logic ex;
        @(negedge clk);
        drive(1, 1'b1, 8'hA5);
        @(posedge clk);
        #1 drive(1, 1'b0, 8'h00);
        for (int n = 0; n <= len + 4; n++) begin
            @(negedge clk);
            o  = obs(1);
            ex = (n < len) ? fr[11 - n] : 1'b0;
            total++; if (o[3] !== ex) begin bad++; $display("FAIL busyv x n=%0d got=%b exp=%b", n, o[3], ex); end
            total++; if (o[1] !== (n >= len)) begin bad++; $display("FAIL busyv ready n=%0d got=%b exp=%b", n, o[1], (n >= len)); end
            total++; if (o[2] !== (n == len)) begin bad++; $display("FAIL busyv frame_done n=%0d got=%b", n, o[2]); end
            if (n == 4) drive(1, 1'b1, 8'h3C);
            if (n == 5) drive(1, 1'b0, 8'h00);
        end
    endtask

    // Abort a frame in DATA; a new word is taken on the first edge after release.
    task automatic test_reset_mid;
        logic [3:0] o;
        @(negedge clk);
        drive(1, 1'b1, 8'hF0);
        @(posedge clk);
        #1 drive(1, 1'b0, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        o = obs(1);
        total++; if (o[3] !== 1'b1) begin bad++; $display("FAIL rstmid pre x got=%b exp=1", o[3]); end
        reset = 1'b0;
        #1;
        check_idle(1, "rstmid");
        check_idle(4, "rstmid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = obs(1);
        total++; if (o[2] !== 1'b0) begin bad++; $display("FAIL rstmid frame_done got=%b exp=0", o[2]); end
        reset = 1'b1;
        send_and_check(1, 8'h5A, 1, "rstmid_5A");
    endtask

    // 100 random words; a 3-bit window detector and a deserializer check each frame.
    task automatic test_loopback;
        logic [7:0] sent[$];
        int rcv = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int guard = 0;
                    logic [7:0] w = 8'($urandom);
                    @(negedge clk);
                    while (if1.ready !== 1'b1 && guard < 100) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 100) begin
                        total++; bad++;
                        $display("FAIL loop ready_timeout got=0 exp=1");
                        break;
                    end
                    if1.valid = 1'b1;
                    if1.din   = w;
                    sent.push_back(w);
                    @(posedge clk);
                    #1 drive(1, 1'b0, 8'($urandom));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                logic b[$];
                logic [2:0] win;
                logic [7:0] got;
                logic [7:0] expw;
                int cyc = 0;
                while (rcv < 100 && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if (if1.busy === 1'b1) b.push_back(if1.x);
                    if (if1.frame_done === 1'b1) begin
                        total++;
                        if (b.size() != 12 || sent.size() == 0) begin
                            bad++;
                            $display("FAIL loop framelen got=%0d exp=12 pending=%0d", b.size(), sent.size());
                        end else begin
                            expw = sent.pop_front();
                            win  = {b[0], b[1], b[2]};
                            for (int i = 0; i < 8; i++) got[7 - i] = b[3 + i];
                            if (win !== sync_v) begin bad++; $display("FAIL loop sync frame=%0d got=%b exp=%b", rcv, win, sync_v); end
                            total++; if (got !== expw) begin bad++; $display("FAIL loop data frame=%0d got=%h exp=%h", rcv, got, expw); end
                            total++; if (b[11] !== 1'b0) begin bad++; $display("FAIL loop gap frame=%0d got=%b exp=0", rcv, b[11]); end
                        end
                        b.delete();
                        rcv++;
                    end
                end
            end
        join
        total++; if (rcv !== 100) begin bad++; $display("FAIL loop frames got=%0d exp=100", rcv); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_stretch;
        test_back_to_back;
        test_busy_valid;
        test_reset_mid;
        test_loopback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
